branch_pred_ctrl: RTL and testbench

BRANCH_PRED_CTRL -- requirements
Module: branch_pred_ctrl

---
 rtl/branch_pred_ctrl_pkg.sv | 23 ++
 rtl/bp_pred_pipe.sv | 30 +++
 rtl/branch_pred_ctrl.sv | 154 +++++++++++++++
 tb/tb_branch_pred_ctrl.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/branch_pred_ctrl_pkg.sv
// Shared types and constants for the branch-prediction controller.
package branch_pred_ctrl_pkg;

  // Predictor controller mode: predictions pass through, or are masked.
  typedef enum logic {
    ST_ACTIVE  = 1'b0,
    ST_BACKOFF = 1'b1
  } bp_state_t;

  // Prediction record that travels with an instruction from F to E.
  typedef struct packed {
    logic        valid;
    logic        taken;
    logic [31:0] target;
  } pred_rec_t;

  // Sequential fetch step, used for the not-taken redirect address.
  localparam logic [31:0] PC_INC = 32'd4;

  // Empty record loaded by flushes and reset.
  localparam pred_rec_t PRED_NONE = '0;

endpackage

// File: rtl/bp_pred_pipe.sv
// F->D->E prediction registers with stall and flush control.
module bp_pred_pipe
  import branch_pred_ctrl_pkg::*;
(
  input  logic      clk,
  input  logic      RESET,
  input  logic      StallD,
  input  logic      FlushD,
  input  logic      FlushE,
  input  pred_rec_t pred_f,
  output pred_rec_t pred_e
);

  pred_rec_t pred_d;

  // D stage: flush wins over stall; stall holds the current record.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses <= so every register samples pre-edge values.
    if (RESET)       pred_d <= PRED_NONE;
    else if (FlushD) pred_d <= PRED_NONE;
    else if (!StallD) pred_d <= pred_f;
  end

  // E stage: always advances from D unless flushed.
  always_ff @(posedge clk) begin
    if (RESET || FlushE) pred_e <= PRED_NONE;
    else                 pred_e <= pred_d;
  end

endmodule

// File: rtl/branch_pred_ctrl.sv
// Branch-prediction controller: masks predictions during back-off,
// detects mispredicts in E, drives redirects/flushes and predictor updates.
module branch_pred_ctrl
  import branch_pred_ctrl_pkg::*;
#(
  parameter int WIN_BITS    = 6,
  parameter int THRESH      = 16,
  parameter int BACKOFF_CYC = 256
) (
  input  logic        clk,
  input  logic        RESET,
  input  logic        PrPCSrc_F,
  input  logic [31:0] PrALUResult_F,
  input  logic        StallD,
  input  logic        FlushE_hz,
  input  logic        Branch_E,
  input  logic        PCSrc_E,
  input  logic [31:0] ALUResult_E,
  input  logic [31:0] PC_E,
  output logic        PredTaken_F,
  output logic [31:0] PredTarget_F,
  output logic        Redirect_E,
  output logic [31:0] RedirectAddr_E,
  output logic        FlushD,
  output logic        FlushE,
  output logic        Upd_WE_PrPCSrc,
  output logic        Upd_WE_PrALUResult,
  output logic [31:0] Upd_PC,
  output logic [31:0] Upd_Target,
  output logic        Upd_Taken,
  output logic        Backoff,
  output logic [15:0] MispredCnt,
  output logic [15:0] BranchCnt
);

  localparam int MIS_W = WIN_BITS + 1;
  localparam int BK_W  = $clog2(BACKOFF_CYC + 1);

  bp_state_t            state, state_nxt;
  logic [WIN_BITS-1:0]  win_cnt;
  logic [MIS_W-1:0]     win_mis, win_mis_nxt;
  logic [BK_W-1:0]      bk_cnt;
  logic                 win_full, bk_done;
  pred_rec_t            pred_f, pred_e;
  logic                 resolve, taken_e, tgt_miss, mispred;

  // Prediction masking: zeroed for the whole back-off period.
  assign PredTaken_F  = (state == ST_ACTIVE) & PrPCSrc_F;
  assign PredTarget_F = (state == ST_ACTIVE) ? PrALUResult_F : '0;
  assign Backoff      = (state == ST_BACKOFF);

  assign pred_f = '{valid: 1'b1, taken: PredTaken_F, target: PredTarget_F};

  bp_pred_pipe u_pipe (
    .clk    (clk),
    .RESET  (RESET),
    .StallD (StallD),
    .FlushD (FlushD),
    .FlushE (FlushE | FlushE_hz),
    .pred_f (pred_f),
    .pred_e (pred_e)
  );

  // Resolution against the prediction the E instruction actually used.
  assign resolve  = Branch_E;
  assign taken_e  = pred_e.valid & pred_e.taken;
  assign tgt_miss = (pred_e.target != ALUResult_E);
  assign mispred  = resolve & ((PCSrc_E != taken_e) | (PCSrc_E & taken_e & tgt_miss));

  assign win_full    = (win_cnt == {WIN_BITS{1'b1}});
  assign win_mis_nxt = win_mis + MIS_W'(mispred);
  assign bk_done     = (bk_cnt == BK_W'(BACKOFF_CYC - 1));

  // Same-cycle mispredict response: redirect fetch and kill D/E.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves a latch.
    Redirect_E     = mispred;
    FlushD         = mispred;
    FlushE         = mispred;
    RedirectAddr_E = '0;
    if (mispred) RedirectAddr_E = PCSrc_E ? ALUResult_E : (PC_E + PC_INC);
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (RESET) state <= ST_ACTIVE;
    else       state <= state_nxt;
  end

  // FSM next state: window-fill decision in ACTIVE, timed exit from BACKOFF.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_ACTIVE:  if (resolve && win_full && (int'(win_mis_nxt) >= THRESH)) state_nxt = ST_BACKOFF;
      ST_BACKOFF: if (bk_done) state_nxt = ST_ACTIVE;
      default:    state_nxt = ST_ACTIVE;
    endcase
  end

  // Window and back-off counters; the filling resolution is counted before clearing.
  always_ff @(posedge clk) begin
    if (RESET) begin
      win_cnt <= '0;
      win_mis <= '0;
      bk_cnt  <= '0;
    end else if (state == ST_ACTIVE) begin
      bk_cnt <= '0;
      if (resolve) begin
        if (win_full) begin
          win_cnt <= '0;
          win_mis <= '0;
        end else begin
          win_cnt <= win_cnt + WIN_BITS'(1);
          win_mis <= win_mis_nxt;
        end
      end
    end else begin
      win_cnt <= '0;
      win_mis <= '0;
      bk_cnt  <= bk_done ? '0 : bk_cnt + BK_W'(1);
    end
  end

  // Predictor update: one strobe cycle after each resolution, operands captured with it.
  always_ff @(posedge clk) begin
    if (RESET) begin
      Upd_WE_PrPCSrc     <= 1'b0;
      Upd_WE_PrALUResult <= 1'b0;
      Upd_PC             <= '0;
      Upd_Target         <= '0;
      Upd_Taken          <= 1'b0;
    end else begin
      Upd_WE_PrPCSrc     <= resolve;
      Upd_WE_PrALUResult <= resolve & PCSrc_E & (~taken_e | tgt_miss);
      if (resolve) begin
        Upd_PC     <= PC_E;
        Upd_Target <= ALUResult_E;
        Upd_Taken  <= PCSrc_E;
      end
    end
  end

  // Lifetime statistics, saturating at all-ones.
  always_ff @(posedge clk) begin
    if (RESET) begin
      BranchCnt  <= '0;
      MispredCnt <= '0;
    end else begin
      if (resolve && (BranchCnt != 16'hFFFF))  BranchCnt  <= BranchCnt + 16'd1;
      if (mispred && (MispredCnt != 16'hFFFF)) MispredCnt <= MispredCnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_branch_pred_ctrl.sv
// Self-checking bench for branch_pred_ctrl: directed cases plus a random run
// compared every cycle against a behavioural model of the controller.
module tb_branch_pred_ctrl;

  localparam int WIN = 64;
  localparam int TH  = 16;
  localparam int BK  = 256;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        RESET, PrPCSrc_F, StallD, FlushE_hz, Branch_E, PCSrc_E;
  logic [31:0] PrALUResult_F, ALUResult_E, PC_E;
  logic        PredTaken_F, Redirect_E, FlushD, FlushE;
  logic [31:0] PredTarget_F, RedirectAddr_E, Upd_PC, Upd_Target;
  logic        Upd_WE_PrPCSrc, Upd_WE_PrALUResult, Upd_Taken, Backoff;
  logic [15:0] MispredCnt, BranchCnt;

  branch_pred_ctrl dut (
    .clk(clk), .RESET(RESET), .PrPCSrc_F(PrPCSrc_F), .PrALUResult_F(PrALUResult_F),
    .StallD(StallD), .FlushE_hz(FlushE_hz), .Branch_E(Branch_E), .PCSrc_E(PCSrc_E),
    .ALUResult_E(ALUResult_E), .PC_E(PC_E), .PredTaken_F(PredTaken_F),
    .PredTarget_F(PredTarget_F), .Redirect_E(Redirect_E), .RedirectAddr_E(RedirectAddr_E),
    .FlushD(FlushD), .FlushE(FlushE), .Upd_WE_PrPCSrc(Upd_WE_PrPCSrc),
    .Upd_WE_PrALUResult(Upd_WE_PrALUResult), .Upd_PC(Upd_PC), .Upd_Target(Upd_Target),
    .Upd_Taken(Upd_Taken), .Backoff(Backoff), .MispredCnt(MispredCnt), .BranchCnt(BranchCnt)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural model: what each stage predicted, plus plain integer bookkeeping.
  bit          m_d_t, m_e_t;
  logic [31:0] m_d_tg, m_e_tg;
  bit          m_bo;
  int          m_bk_left, m_win_res, m_win_mis;
  bit          m_we_pc, m_we_tgt, m_upd_taken;
  logic [31:0] m_upd_pc, m_upd_tgt;
  int          m_br, m_mis;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit model_mis();
    if (!Branch_E) return 1'b0;
    if (PCSrc_E != m_e_t) return 1'b1;
    return PCSrc_E && m_e_t && (m_e_tg != ALUResult_E);
  endfunction

  task automatic model_clear();
    m_d_t = 0; m_d_tg = 0; m_e_t = 0; m_e_tg = 0;
    m_bo = 0; m_bk_left = 0; m_win_res = 0; m_win_mis = 0;
    m_we_pc = 0; m_we_tgt = 0; m_upd_taken = 0; m_upd_pc = 0; m_upd_tgt = 0;
    m_br = 0; m_mis = 0;
  endtask

  task automatic model_step(input bit mis);
    bit          f_t, od_t;
    logic [31:0] f_tg, od_tg;
    if (RESET) begin
      model_clear();
    end else begin
      f_t  = m_bo ? 1'b0 : PrPCSrc_F;
      f_tg = m_bo ? 32'd0 : PrALUResult_F;
      od_t = m_d_t; od_tg = m_d_tg;
      m_we_pc  = Branch_E;
      m_we_tgt = Branch_E && PCSrc_E && (!m_e_t || (m_e_tg != ALUResult_E));
      if (Branch_E) begin
        m_upd_pc = PC_E; m_upd_tgt = ALUResult_E; m_upd_taken = PCSrc_E;
      end
      if (mis) begin m_d_t = 0; m_d_tg = 0; end
      else if (!StallD) begin m_d_t = f_t; m_d_tg = f_tg; end
      if (mis || FlushE_hz) begin m_e_t = 0; m_e_tg = 0; end
      else begin m_e_t = od_t; m_e_tg = od_tg; end
      if (Branch_E && m_br < 65535) m_br++;
      if (mis && m_mis < 65535) m_mis++;
      if (!m_bo) begin
        if (Branch_E) begin
          m_win_res++;
          m_win_mis += int'(mis);
          if (m_win_res == WIN) begin
            if (m_win_mis >= TH) begin m_bo = 1; m_bk_left = BK; end
            m_win_res = 0; m_win_mis = 0;
          end
        end
      end else begin
        m_bk_left--;
        if (m_bk_left == 0) m_bo = 0;
      end
    end
  endtask

  // One clock: compare every output with the model, then advance both.
  task automatic cycle();
    bit          mis;
    logic [31:0] addr;
    #1;
    mis  = model_mis();
    addr = mis ? (PCSrc_E ? ALUResult_E : PC_E + 32'd4) : 32'd0;
    check("pred_taken", PredTaken_F, m_bo ? 1'b0 : PrPCSrc_F);
    check("pred_target", PredTarget_F, m_bo ? 32'd0 : PrALUResult_F);
    check("redirect", Redirect_E, mis);
    check("redirect_addr", RedirectAddr_E, addr);
    check("flush_d", FlushD, mis);
    check("flush_e", FlushE, mis);
    check("upd_we_pcsrc", Upd_WE_PrPCSrc, m_we_pc);
    check("upd_we_target", Upd_WE_PrALUResult, m_we_tgt);
    check("backoff", Backoff, m_bo);
    check("branch_cnt", BranchCnt, m_br);
    check("mispred_cnt", MispredCnt, m_mis);
    if (m_we_pc) begin
      check("upd_pc", Upd_PC, m_upd_pc);
      check("upd_target", Upd_Target, m_upd_tgt);
      check("upd_taken", Upd_Taken, m_upd_taken);
    end
    @(posedge clk);
    model_step(mis);
    #1;
  endtask

  task automatic idle();
    PrPCSrc_F = 0; PrALUResult_F = 0; StallD = 0; FlushE_hz = 0;
    Branch_E = 0; PCSrc_E = 0; ALUResult_E = 0; PC_E = 0;
  endtask

  task automatic do_reset();
    RESET = 1; cycle(); RESET = 0;
  endtask

  // Push a prediction from F into E over two idle cycles.
  task automatic load_pred(input bit t, input logic [31:0] tg);
    idle();
    PrPCSrc_F = t; PrALUResult_F = tg; cycle();
    PrPCSrc_F = 0; PrALUResult_F = 0; cycle();
  endtask

  // One full window of back-to-back resolutions with n_mis mispredicts first.
  task automatic run_window(input int n_mis);
    idle();
    for (int i = 0; i < WIN; i++) begin
      Branch_E = 1; PCSrc_E = (i < n_mis); ALUResult_E = 32'h900; PC_E = 32'(i) * 4;
      cycle();
    end
    idle();
  endtask

  initial begin
    idle();
    RESET = 1;
    model_clear();
    @(posedge clk); @(posedge clk); #1;
    RESET = 0;
    check("reset_backoff", Backoff, 1'b0);
    check("reset_branch_cnt", BranchCnt, 16'd0);
    check("reset_mispred_cnt", MispredCnt, 16'd0);
    check("reset_upd_we", Upd_WE_PrPCSrc, 1'b0);

    // Correct taken prediction: no redirect, update without target write.
    load_pred(1, 32'h100);
    Branch_E = 1; PCSrc_E = 1; ALUResult_E = 32'h100; PC_E = 32'h20;
    #1 check("hit_no_redirect", Redirect_E, 1'b0);
    cycle(); idle();
    check("hit_upd_we_pc", Upd_WE_PrPCSrc, 1'b1);
    check("hit_upd_we_tgt", Upd_WE_PrALUResult, 1'b0);
    cycle();

    // Predicted not-taken, actually taken.
    load_pred(0, 32'h0);
    Branch_E = 1; PCSrc_E = 1; ALUResult_E = 32'h80; PC_E = 32'h40;
    #1;
    check("nt_redirect", Redirect_E, 1'b1);
    check("nt_addr", RedirectAddr_E, 32'h80);
    check("nt_flush_d", FlushD, 1'b1);
    check("nt_flush_e", FlushE, 1'b1);
    cycle(); idle();
    check("nt_upd_we_pc", Upd_WE_PrPCSrc, 1'b1);
    check("nt_upd_we_tgt", Upd_WE_PrALUResult, 1'b1);
    check("nt_upd_target", Upd_Target, 32'h80);
    cycle();

    // Predicted taken, actually not-taken.
    load_pred(1, 32'h300);
    Branch_E = 1; PCSrc_E = 0; ALUResult_E = 32'h300; PC_E = 32'h40;
    #1 check("tk_addr", RedirectAddr_E, 32'h44);
    cycle(); idle();
    check("tk_upd_we_tgt", Upd_WE_PrALUResult, 1'b0);
    check("tk_upd_taken", Upd_Taken, 1'b0);
    cycle();

    // Not-taken redirect wraps at the top of the address space.
    load_pred(1, 32'h300);
    Branch_E = 1; PCSrc_E = 0; PC_E = 32'hFFFF_FFFC;
    #1 check("wrap_addr", RedirectAddr_E, 32'h0);
    cycle();

    // Taken with wrong target: mispredict with target write.
    load_pred(1, 32'h300);
    Branch_E = 1; PCSrc_E = 1; ALUResult_E = 32'h304; PC_E = 32'h10;
    #1 check("tgt_miss_addr", RedirectAddr_E, 32'h304);
    cycle(); idle();
    check("tgt_miss_we_tgt", Upd_WE_PrALUResult, 1'b1);
    cycle();

    // Stall D with E flushed: E empties, D keeps its taken prediction.
    idle();
    PrPCSrc_F = 1; PrALUResult_F = 32'h500; cycle();
    PrPCSrc_F = 0; PrALUResult_F = 0; StallD = 1; FlushE_hz = 1; cycle();
    StallD = 0; FlushE_hz = 0; Branch_E = 1; PCSrc_E = 0;
    #1 check("stall_e_empty", Redirect_E, 1'b0);
    cycle();
    PCSrc_E = 1; ALUResult_E = 32'h500;
    #1 check("stall_d_held", Redirect_E, 1'b0);
    cycle(); idle(); cycle();

    // Threshold boundary: 15 then 1 mispredict in separate windows, no back-off.
    do_reset();
    run_window(TH - 1);
    check("below_thresh", Backoff, 1'b0);
    run_window(1);
    check("window_cleared", Backoff, 1'b0);

    // Exactly THRESH mispredicts: back-off, masking for BK cycles, then resume.
    do_reset();
    run_window(TH);
    check("enter_backoff", Backoff, 1'b1);
    check("win_branch_cnt", BranchCnt, 16'd64);
    check("win_mispred_cnt", MispredCnt, 16'd16);
    PrPCSrc_F = 1; PrALUResult_F = 32'h700;
    for (int i = 0; i < BK; i++) begin
      #1 check("masked", PredTaken_F, 1'b0);
      cycle();
    end
    check("exit_backoff", Backoff, 1'b0);
    #1 check("unmasked", PredTaken_F, 1'b1);
    cycle();

    // Reset in the 100th back-off cycle with an update pending.
    do_reset();
    run_window(TH);
    for (int i = 1; i < 100; i++) begin
      Branch_E = (i == 99); PCSrc_E = 0;
      cycle();
    end
    RESET = 1; Branch_E = 1; cycle();
    RESET = 0; idle();
    check("rst_backoff", Backoff, 1'b0);
    check("rst_branch_cnt", BranchCnt, 16'd0);
    check("rst_mispred_cnt", MispredCnt, 16'd0);
    check("rst_upd_we_pc", Upd_WE_PrPCSrc, 1'b0);
    check("rst_upd_we_tgt", Upd_WE_PrALUResult, 1'b0);
    cycle();
    check("rst_no_strobe", Upd_WE_PrPCSrc, 1'b0);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      RESET         = ($urandom_range(0, 599) == 0);
      PrPCSrc_F     = 1'($urandom_range(0, 1));
      PrALUResult_F = 32'($urandom_range(1, 3)) << 8;
      StallD        = ($urandom_range(0, 4) == 0);
      FlushE_hz     = ($urandom_range(0, 9) == 0);
      Branch_E      = 1'($urandom_range(0, 1));
      PCSrc_E       = 1'($urandom_range(0, 1));
      ALUResult_E   = 32'($urandom_range(1, 3)) << 8;
      PC_E          = $urandom;
      cycle();
    end
    RESET = 0; idle(); cycle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
